// File: rtl/pwm_duty_meter.sv
// PWM duty meter: counts high cycles of a synchronized PWM input over fixed
// windows of 2^WIN_BITS clocks, reports the count with a strobe, flags duty
// changes and detects sustained full-on / full-off levels.
module pwm_duty_meter #(
    parameter int unsigned WIN_BITS    = 6,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                Pulse_In,
    output logic [WIN_BITS:0]   Duty,
    output logic                Duty_Valid,
    output logic                Change,
    output logic                Level_High,
    output logic                Level_Low
);

    localparam int unsigned     WinLen = 1 << WIN_BITS;
    localparam logic [WIN_BITS:0] Full = WinLen[WIN_BITS:0];
    localparam logic [3:0]      Hold = HOLD_FRAMES[3:0];

    typedef enum logic {StFirst, StRun} state_e;

    state_e                state;
    logic [1:0]            sync_q;
    logic                  s;
    logic [WIN_BITS-1:0]   win_cnt;
    logic [WIN_BITS:0]     hi_cnt;
    logic [3:0]            full_run;
    logic [3:0]            zero_run;

    logic                  win_last;
    logic [WIN_BITS:0]     new_duty;
    logic [3:0]            full_run_nxt;
    logic [3:0]            zero_run_nxt;

    assign s = sync_q[1];

    // Window-end values: the closing sample is folded into the reported count.
    always_comb begin
        win_last     = &win_cnt;
        new_duty     = hi_cnt + {{WIN_BITS{1'b0}}, s};
        full_run_nxt = 4'd0;
        zero_run_nxt = 4'd0;
        if (new_duty == Full) begin
            full_run_nxt = (full_run == Hold) ? Hold : full_run + 4'd1;
        end
        if (new_duty == '0) begin
            zero_run_nxt = (zero_run == Hold) ? Hold : zero_run + 4'd1;
        end
    end

    // Synchronizer, window counters, and registered outputs with FIRST/RUN state.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state      <= StFirst;
            sync_q     <= 2'b00;
            win_cnt    <= '0;
            hi_cnt     <= '0;
            full_run   <= 4'd0;
            zero_run   <= 4'd0;
            Duty       <= '0;
            Duty_Valid <= 1'b0;
            Change     <= 1'b0;
            Level_High <= 1'b0;
            Level_Low  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], Pulse_In};
            win_cnt    <= win_cnt + 1'b1;
            Duty_Valid <= 1'b0;
            Change     <= 1'b0;
            if (win_last) begin
                hi_cnt     <= '0;
                Duty       <= new_duty;
                Duty_Valid <= 1'b1;
                full_run   <= full_run_nxt;
                zero_run   <= zero_run_nxt;
                Level_High <= (full_run_nxt == Hold);
                Level_Low  <= (zero_run_nxt == Hold);
                case (state)
                    StFirst: begin
                        Change <= 1'b0;
                        state  <= StRun;
                    end
                    default: begin
                        Change <= (new_duty != Duty);
                    end
                endcase
            end else begin
                hi_cnt <= hi_cnt + {{WIN_BITS{1'b0}}, s};
            end
        end
    end

endmodule
